// File: rtl/vme_master_transfer.sv
// VME master data-transfer sequencer: bridges a 68030 bus cycle onto VMEbus with AM generation,
// programmable AS->DS setup, optional D32, DTACK timeout and rescind-safe release.
module vme_master_transfer #(
  parameter int unsigned DS_DELAY   = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned ENABLE_D32 = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       request_vme,
  input  logic       bus_acquired,
  input  logic       cpu_as,
  input  logic       cpu_ds,
  input  logic       cpu_write,
  input  logic [1:0] cpu_siz,
  input  logic [1:0] cpu_address,
  input  logic [2:0] cpu_fc,
  input  logic [1:0] addr_space,
  output logic [1:0] cpu_dsack,
  output logic       cpu_berr,
  output logic       vme_as,
  output logic [1:0] vme_ds,
  output logic       vme_lword,
  output logic       vme_write,
  output logic [5:0] vme_address_mod,
  input  logic       vme_dtack,
  input  logic       vme_berr,
  output logic       addr_low_oe,
  output logic       data_low_oe,
  output logic       d16_cross_oe,
  output logic       md32_cross_oe,
  output logic       data_low_dir,
  output logic       d16_cross_dir,
  output logic       md32_cross_dir,
  output logic       busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_ACK     = 3'd3;
  localparam logic [2:0] ST_RELEASE = 3'd4;

  localparam logic [3:0]  DLY_LAST = 4'(DS_DELAY - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  dly_q, dly_d;
  logic [15:0] tmo_q, tmo_d;
  logic [5:0]  am_q, am_d;
  logic        d32_q, d32_d;
  logic        read_q, read_d;
  logic [1:0]  ds_q, ds_d;
  logic [2:0]  lane_q, lane_d;   // active-low {data_low, d16_cross, md32_cross}
  logic        berr_q, berr_d;

  logic        d32_dec;
  logic        byte_dec;
  logic [1:0]  ds_dec;
  logic [2:0]  lane_dec;
  logic [5:0]  am_dec;

  function automatic logic [5:0] am_code(input logic [2:0] fc, input logic [1:0] sp);
    logic s;
    logic p;
    s = fc[2];
    p = (fc[1:0] == 2'b10);
    case (sp)
      2'b00:   am_code = s ? 6'h2D : 6'h29;
      2'b01:   am_code = s ? (p ? 6'h3E : 6'h3D) : (p ? 6'h3A : 6'h39);
      default: am_code = s ? (p ? 6'h0E : 6'h0D) : (p ? 6'h0A : 6'h09);
    endcase
  endfunction

  always_comb begin
    d32_dec  = (ENABLE_D32 != 0) && (cpu_siz == 2'b00) && (cpu_address == 2'b00);
    byte_dec = (cpu_siz == 2'b01) || cpu_address[0];
    if (d32_dec)       ds_dec = 2'b00;
    else if (byte_dec) ds_dec = cpu_address[0] ? 2'b10 : 2'b01;
    else               ds_dec = 2'b00;
    if (d32_dec)             lane_dec = 3'b010;
    else if (cpu_address[1]) lane_dec = 3'b011;
    else                     lane_dec = 3'b101;
    am_dec = am_code(cpu_fc, addr_space);
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    tmo_d   = tmo_q;
    am_d    = am_q;
    d32_d   = d32_q;
    read_d  = read_q;
    ds_d    = ds_q;
    lane_d  = lane_q;
    berr_d  = berr_q;
    case (state_q)
      ST_IDLE: begin
        if (!request_vme && !bus_acquired && !cpu_as) begin
          state_d = ST_ADDR;
          dly_d   = '0;
          am_d    = am_dec;
          d32_d   = d32_dec;
          read_d  = cpu_write;
          ds_d    = ds_dec;
          lane_d  = lane_dec;
          berr_d  = 1'b0;
        end
      end
      ST_ADDR: begin
        if (cpu_as) begin
          state_d = ST_RELEASE;
        end else if (dly_q != DLY_LAST) begin
          dly_d = dly_q + 4'd1;
        end else if (!cpu_ds) begin
          state_d = ST_DATA;
          tmo_d   = '0;
        end
      end
      ST_DATA: begin
        // Abort beats any response; berr beats dtack when both arrive together.
        if (cpu_as) begin
          state_d = ST_RELEASE;
        end else if (!vme_berr) begin
          state_d = ST_ACK;
          berr_d  = 1'b1;
        end else if (!vme_dtack) begin
          state_d = ST_ACK;
          berr_d  = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_ACK;
          berr_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_ACK: begin
        if (cpu_as) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (vme_dtack && vme_berr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      tmo_q   <= '0;
      am_q    <= '0;
      d32_q   <= 1'b0;
      read_q  <= 1'b0;
      ds_q    <= '1;
      lane_q  <= '1;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      tmo_q   <= tmo_d;
      am_q    <= am_d;
      d32_q   <= d32_d;
      read_q  <= read_d;
      ds_q    <= ds_d;
      lane_q  <= lane_d;
      berr_q  <= berr_d;
    end
  end

  logic in_cycle;
  logic in_data;
  logic in_ack;

  always_comb begin
    in_cycle = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_ACK);
    in_data  = (state_q == ST_DATA) || (state_q == ST_ACK);
    in_ack   = (state_q == ST_ACK);
  end

  // Strobes and buffers hold through ACK so read data stays stable until the CPU ends the cycle.
  assign vme_as          = ~in_cycle;
  assign vme_ds          = in_data ? ds_q : 2'b11;
  assign vme_lword       = ~(in_cycle & d32_q);
  assign vme_write       = ~(in_cycle & ~read_q);
  assign vme_address_mod = am_q;
  assign addr_low_oe     = ~in_cycle;
  assign data_low_oe     = in_data ? lane_q[2] : 1'b1;
  assign d16_cross_oe    = in_data ? lane_q[1] : 1'b1;
  assign md32_cross_oe   = in_data ? lane_q[0] : 1'b1;
  assign data_low_dir    = ~(in_cycle & read_q);
  assign d16_cross_dir   = ~(in_cycle & read_q);
  assign md32_cross_dir  = ~(in_cycle & read_q);
  assign cpu_berr        = ~(in_ack & berr_q);
  assign cpu_dsack       = (in_ack && !berr_q) ? (d32_q ? 2'b00 : 2'b01) : 2'b11;
  assign busy            = (state_q != ST_IDLE);

endmodule
